dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port: the target end of the load/store interface.
- Accepts one load/store request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- Performs the word access with byte strobes against an internal array and returns the result over a second valid/ready handshake.
- Sits between the core's LSU-side request logic and on-chip data RAM; replaces the combinational data memory once the core moves to a stalling memory interface.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the internal array; power of two, at least 4.
- WAIT_STATES, 2, idle cycles between request acceptance and memory access; range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be a multiple of DEPTH_WORDS*4.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_wdata  in  32  store data, lane-aligned (byte k on bits 8k+7:8k).
- req_be  in  4  byte strobes; bit k enables lane k.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data, full word; 0 for stores and errors.
- rsp_err  out  1  access fault for this response.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset: while reset is low, state=IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0; wait counter=0.
  - The array is not cleared by reset.
- IDLE:
  - req_ready=1.
  - Acceptance happens on a rising edge with req_valid=1; addr, we, wdata and be are captured.
  - With WAIT_STATES=0, go to RESP. Otherwise go to WAIT with counter=WAIT_STATES-1.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; when counter=0, go to RESP on the next edge.
- Memory access occurs on the edge that enters RESP:
  - Load: array word registered into rsp_rdata.
  - Store: each lane with be[k]=1 is written; lanes with be[k]=0 are unchanged; rsp_rdata=0.
- Latency: rsp_valid is first high WAIT_STATES+1 cycles after the acceptance edge.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until the handshake.
  - On an edge with rsp_ready=1, go to IDLE and clear rsp_valid, rsp_rdata and rsp_err.
  - req_ready=0 throughout RESP, so a request presented during RESP is not accepted until IDLE.
  - Peak throughput is one transaction per WAIT_STATES+2 cycles.
- Error detection uses the captured request; rsp_err=1 if any of these holds:
  - addr[1:0] != 0;
  - (addr - BASE_ADDR) is outside 0 .. DEPTH_WORDS*4-1, with unsigned 32-bit wrap;
  - be == 4'b0000.
- On error: no array write, rsp_rdata=0; the response is still delivered with normal latency.
- Word index = (addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- Reset asserted mid-transaction:
  - Immediate return to IDLE; the response is dropped.
  - A store not yet committed (state WAIT) is discarded.
- Request inputs are ignored outside the acceptance edge; changes to them during WAIT or RESP have no effect.

Test Plan:
- WAIT_STATES=2: store addr 0x10, wdata 0xDEADBEEF, be 4'hF, then load 0x10 -> rsp_valid 3 cycles after each accept; load returns 0xDEADBEEF with rsp_err=0.
- Byte-strobe merge: store 0xAABBCCDD be=F to 0x20, then store 0x11223344 be=4'b0101, then load 0x20 -> 0xAA22CC44.
- Errors: load 0x22 (misaligned), load BASE_ADDR+DEPTH_WORDS*4 (out of range), store be=0 to 0x30 -> each gives rsp_err=1, rsp_rdata=0; a subsequent load of 0x30 shows the prior contents unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err are stable, req_ready=0, and a new req_valid is not accepted; release -> IDLE next cycle, then the pending request is accepted.
- WAIT_STATES=0: load 0x0 -> rsp_valid the cycle after the accept; back-to-back requests with rsp_ready=1 complete one per 2 cycles.
- Reset: assert reset (low) during WAIT of a store of 0x12345678 to 0x40 -> outputs return to reset values asynchronously; after release, load 0x40 returns the old value, not 0x12345678.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target with valid/ready request/response, wait states and byte strobes
// Ports: clk; reset (async, active low); req_valid/req_ready/req_addr/req_we/req_wdata/req_be request channel;
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err response channel; busy = not IDLE.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT0 = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [31:0] addr, wdata;
  logic we;
  logic [3:0] be;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] c_addr, c_wdata, off;
  logic c_we, c_err, enter_resp, wr_en;
  logic [3:0] c_be;
  logic [AW-1:0] idx;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (req_valid ? (WAIT_STATES == 0 ? RESP : WAIT) : IDLE)
             : (state == WAIT) ? (cnt == 4'd0 ? RESP : WAIT)
             : (rsp_ready ? IDLE : RESP);
  end
  // With no wait states the access happens on the acceptance edge, before the capture registers load,
  // so the live request inputs are used while in IDLE.
  always_comb begin
    c_addr = (state == IDLE) ? req_addr : addr;
    c_wdata = (state == IDLE) ? req_wdata : wdata;
    c_we = (state == IDLE) ? req_we : we;
    c_be = (state == IDLE) ? req_be : be;
    off = c_addr - BASE_ADDR;
    c_err = (|off[1:0]) || (|off[31:AW+2]) || (c_be == 4'b0000);
    idx = off[AW+1:2];
    enter_resp = (state_nx == RESP) && (state != RESP);
    wr_en = enter_resp && c_we && !c_err && reset;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      addr <= '0;
      wdata <= '0;
      we <= 1'b0;
      be <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr <= req_addr;
        wdata <= req_wdata;
        we <= req_we;
        be <= req_be;
        cnt <= CNT0;
      end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (enter_resp) begin
        rsp_rdata <= (c_we || c_err) ? '0 : mem[idx];
        rsp_err <= c_err;
      end else if (state == RESP && rsp_ready) begin
        rsp_rdata <= '0;
        rsp_err <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk)
    for (int k = 0; k < 4; k++)
      if (wr_en && c_be[k]) mem[idx][8*k +: 8] <= c_wdata[8*k +: 8];
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a word-array model
module tb_dmem_responder;
  logic clk = 0;
  logic reset = 0;
  logic req_valid [2];
  logic req_ready [2];
  logic req_we [2];
  logic rsp_valid [2];
  logic rsp_ready [2];
  logic rsp_err [2];
  logic busy [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata [2];
  logic [3:0] req_be [2];
  int total = 0;
  int bad = 0;
  bit [31:0] mdl [2][1024];
  bit known [2][1024];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0000_0000)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_we(req_we[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0]));

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0), .BASE_ADDR(32'h0000_1000)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_we(req_we[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1]));

  // Instance 0: 1024 words, 2 wait states, base 0. Instance 1: 16 words, no wait states, base 0x1000.
  function automatic void model(input int i, input logic [31:0] ad, input logic we, input logic [31:0] wd,
                                input logic [3:0] be, output logic [31:0] rd, output logic err, output bit chk);
    logic [31:0] off;
    int w;
    int dep;
    dep = (i == 1) ? 16 : 1024;
    off = ad - ((i == 1) ? 32'h1000 : 32'h0);
    err = (ad % 4 != 0) || (off >= 32'(dep * 4)) || (be == 4'b0000);
    rd = 32'h0;
    chk = 1;
    if (!err) begin
      w = int'(off / 4);
      if (we) begin
        for (int k = 0; k < 4; k++) if (be[k]) mdl[i][w][8*k +: 8] = wd[8*k +: 8];
        if (be == 4'hF) known[i][w] = 1;
      end else begin
        rd = mdl[i][w];
        chk = known[i][w];
      end
    end
  endfunction

  // Issues one request from IDLE, returns the response and the number of edges from acceptance to rsp_valid.
  task automatic txn(input int i, input logic [31:0] ad, input logic we, input logic [31:0] wd, input logic [3:0] be,
                     input int hold, output logic [31:0] rd, output logic err, output int lat);
    req_addr[i] = ad; req_we[i] = we; req_wdata[i] = wd; req_be[i] = be; req_valid[i] = 1;
    @(posedge clk); #1;
    req_valid[i] = 0;
    lat = 0; rd = 32'h0; err = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (rsp_valid[i]) begin lat = n; break; end
      @(posedge clk); #1;
    end
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL txn_timeout inst=%0d addr=%h got no rsp_valid want rsp_valid within 40 cycles", i, ad);
      return;
    end
    repeat (hold) begin @(posedge clk); #1; end
    rd = rsp_rdata[i]; err = rsp_err[i];
    rsp_ready[i] = 1;
    @(posedge clk); #1;
    rsp_ready[i] = 0;
  endtask

  task automatic test_reset;
    #12;
    for (int i = 0; i < 2; i++) begin
      total++; if (req_ready[i] !== 1'b1) begin bad++; $display("FAIL reset_req_ready inst=%0d got=%b want=1", i, req_ready[i]); end
      total++; if (rsp_valid[i] !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid inst=%0d got=%b want=0", i, rsp_valid[i]); end
      total++; if (rsp_rdata[i] !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata inst=%0d got=%h want=0", i, rsp_rdata[i]); end
      total++; if (rsp_err[i] !== 1'b0) begin bad++; $display("FAIL reset_rsp_err inst=%0d got=%b want=0", i, rsp_err[i]); end
      total++; if (busy[i] !== 1'b0) begin bad++; $display("FAIL reset_busy inst=%0d got=%b want=0", i, busy[i]); end
    end
    reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [31:0] rd, erd; logic err, eerr; bit chk; int lat;
    model(0, 32'h10, 1, 32'hDEADBEEF, 4'hF, erd, eerr, chk);
    txn(0, 32'h10, 1, 32'hDEADBEEF, 4'hF, 0, rd, err, lat);
    total++; if (lat != 3) begin bad++; $display("FAIL basic_store_latency got=%0d want=3", lat); end
    total++; if (err !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL basic_store_rsp got err=%b rdata=%h want err=0 rdata=0", err, rd); end
    model(0, 32'h10, 0, 32'h0, 4'hF, erd, eerr, chk);
    txn(0, 32'h10, 0, 32'h0, 4'hF, 0, rd, err, lat);
    total++; if (lat != 3) begin bad++; $display("FAIL basic_load_latency got=%0d want=3", lat); end
    total++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin bad++; $display("FAIL basic_load got rdata=%h err=%b want rdata=deadbeef err=0", rd, err); end
  endtask

  task automatic test_merge;
    logic [31:0] rd, erd; logic err, eerr; bit chk; int lat;
    model(0, 32'h20, 1, 32'hAABBCCDD, 4'hF, erd, eerr, chk);
    txn(0, 32'h20, 1, 32'hAABBCCDD, 4'hF, 0, rd, err, lat);
    model(0, 32'h20, 1, 32'h11223344, 4'b0101, erd, eerr, chk);
    txn(0, 32'h20, 1, 32'h11223344, 4'b0101, 1, rd, err, lat);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL merge_partial_store_err got=%b want=0", err); end
    model(0, 32'h20, 0, 32'h0, 4'hF, erd, eerr, chk);
    txn(0, 32'h20, 0, 32'h0, 4'hF, 0, rd, err, lat);
    total++; if (rd !== 32'hAA22CC44 || err !== 1'b0) begin bad++; $display("FAIL merge_load got rdata=%h err=%b want rdata=aa22cc44 err=0", rd, err); end
  endtask

  task automatic test_errors;
    logic [31:0] rd, erd; logic err, eerr; bit chk; int lat;
    logic [31:0] ads [3] = '{32'h22, 32'h1000, 32'h30};
    logic wes [3] = '{1'b0, 1'b0, 1'b1};
    logic [3:0] bes [3] = '{4'hF, 4'hF, 4'h0};
    model(0, 32'h30, 1, 32'h55667788, 4'hF, erd, eerr, chk);
    txn(0, 32'h30, 1, 32'h55667788, 4'hF, 0, rd, err, lat);
    for (int t = 0; t < 3; t++) begin
      model(0, ads[t], wes[t], 32'hFFFFFFFF, bes[t], erd, eerr, chk);
      txn(0, ads[t], wes[t], 32'hFFFFFFFF, bes[t], 0, rd, err, lat);
      total++; if (err !== 1'b1 || rd !== 32'h0 || lat != 3) begin bad++; $display("FAIL error_case%0d addr=%h got err=%b rdata=%h lat=%0d want err=1 rdata=0 lat=3", t, ads[t], err, rd, lat); end
    end
    model(0, 32'h30, 0, 32'h0, 4'hF, erd, eerr, chk);
    txn(0, 32'h30, 0, 32'h0, 4'hF, 0, rd, err, lat);
    total++; if (rd !== 32'h55667788 || err !== 1'b0) begin bad++; $display("FAIL error_no_write got rdata=%h err=%b want rdata=55667788 err=0", rd, err); end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd, erd, erd2; logic err, eerr; bit chk; int lat; bit seen;
    model(0, 32'h10, 0, 32'h0, 4'hF, erd, eerr, chk);
    req_addr[0] = 32'h10; req_we[0] = 0; req_be[0] = 4'hF; req_valid[0] = 1;
    @(posedge clk); #1;
    req_valid[0] = 0;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (rsp_valid[0]) seen = 1; else begin @(posedge clk); #1; end
    end
    total++; if (!seen) begin bad++; $display("FAIL bp_first_rsp got no rsp_valid want rsp_valid"); end
    req_addr[0] = 32'h20; req_we[0] = 0; req_be[0] = 4'hF; req_wdata[0] = 32'h0; req_valid[0] = 1;
    repeat (5) begin
      @(posedge clk); #1;
      total++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== erd || rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold got valid=%b rdata=%h err=%b req_ready=%b want valid=1 rdata=%h err=0 req_ready=0",
                 rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0], erd);
      end
    end
    rsp_ready[0] = 1;
    @(posedge clk); #1;
    rsp_ready[0] = 0;
    total++; if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin bad++; $display("FAIL bp_release got valid=%b req_ready=%b want valid=0 req_ready=1", rsp_valid[0], req_ready[0]); end
    @(posedge clk); #1;
    req_valid[0] = 0;
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL bp_pending_accept got busy=%b want 1", busy[0]); end
    model(0, 32'h20, 0, 32'h0, 4'hF, erd2, eerr, chk);
    lat = 0;
    for (int n = 2; n <= 20; n++) begin
      @(posedge clk); #1;
      if (rsp_valid[0]) begin lat = n; break; end
    end
    rd = rsp_rdata[0]; err = rsp_err[0];
    rsp_ready[0] = 1;
    @(posedge clk); #1;
    rsp_ready[0] = 0;
    total++; if (lat != 3 || rd !== erd2 || err !== 1'b0) begin bad++; $display("FAIL bp_second got lat=%0d rdata=%h err=%b want lat=3 rdata=%h err=0", lat, rd, err, erd2); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd, erd; logic err, eerr; bit chk; int lat;
    model(0, 32'h40, 1, 32'hCAFEF00D, 4'hF, erd, eerr, chk);
    txn(0, 32'h40, 1, 32'hCAFEF00D, 4'hF, 0, rd, err, lat);
    req_addr[0] = 32'h40; req_we[0] = 1; req_wdata[0] = 32'h12345678; req_be[0] = 4'hF; req_valid[0] = 1;
    @(posedge clk); #1;
    req_valid[0] = 0;
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL rmid_in_wait got busy=%b want 1", busy[0]); end
    #2 reset = 0;
    #1;
    total++;
    if (busy[0] !== 1'b0 || req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'h0 || rsp_err[0] !== 1'b0) begin
      bad++;
      $display("FAIL rmid_async got busy=%b req_ready=%b valid=%b rdata=%h err=%b want 0 1 0 0 0",
               busy[0], req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0]);
    end
    #2 reset = 1;
    repeat (4) begin @(posedge clk); #1; end
    total++; if (rsp_valid[0] !== 1'b0) begin bad++; $display("FAIL rmid_dropped got rsp_valid=%b want 0", rsp_valid[0]); end
    model(0, 32'h40, 0, 32'h0, 4'hF, erd, eerr, chk);
    txn(0, 32'h40, 0, 32'h0, 4'hF, 0, rd, err, lat);
    total++; if (rd !== 32'hCAFEF00D || err !== 1'b0) begin bad++; $display("FAIL rmid_old_value got rdata=%h err=%b want rdata=cafef00d err=0", rd, err); end
  endtask

  task automatic test_ws0;
    logic [31:0] rd, erd; logic err, eerr; bit chk; int lat; int cnt;
    model(1, 32'h1000, 1, 32'h0BADF00D, 4'hF, erd, eerr, chk);
    txn(1, 32'h1000, 1, 32'h0BADF00D, 4'hF, 0, rd, err, lat);
    total++; if (lat != 1 || err !== 1'b0) begin bad++; $display("FAIL ws0_store got lat=%0d err=%b want lat=1 err=0", lat, err); end
    model(1, 32'h1000, 0, 32'h0, 4'hF, erd, eerr, chk);
    txn(1, 32'h1000, 0, 32'h0, 4'hF, 0, rd, err, lat);
    total++; if (lat != 1 || rd !== 32'h0BADF00D) begin bad++; $display("FAIL ws0_load got lat=%0d rdata=%h want lat=1 rdata=0badf00d", lat, rd); end
    req_addr[1] = 32'h1000; req_we[1] = 0; req_be[1] = 4'hF; req_valid[1] = 1; rsp_ready[1] = 1;
    cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid[1]) begin
        cnt++;
        total++; if (rsp_rdata[1] !== 32'h0BADF00D) begin bad++; $display("FAIL ws0_b2b_data got=%h want=0badf00d", rsp_rdata[1]); end
      end
    end
    req_valid[1] = 0; rsp_ready[1] = 0;
    total++; if (cnt != 4) begin bad++; $display("FAIL ws0_b2b_rate got=%0d responses in 8 cycles want=4", cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [31:0] rd, erd, ad, wd, b; logic err, eerr, we; logic [3:0] be; bit chk; int lat, dep, r;
    for (int i = 0; i < 2; i++) begin
      b = (i == 1) ? 32'h1000 : 32'h0;
      dep = (i == 1) ? 16 : 1024;
      for (int w = 0; w < 16; w++) begin
        wd = $urandom;
        model(i, b + 32'(4 * w), 1, wd, 4'hF, erd, eerr, chk);
        txn(i, b + 32'(4 * w), 1, wd, 4'hF, 0, rd, err, lat);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rand_init inst=%0d word=%0d got err=%b want 0", i, w, err); end
      end
      for (int t = 0; t < 60; t++) begin
        r = $urandom_range(0, 9);
        ad = (r < 7) ? b + 32'(4 * $urandom_range(0, 15))
           : (r == 7) ? b + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3))
           : (r == 8) ? b + 32'(dep * 4) + 32'(4 * $urandom_range(0, 3))
           : b - 32'd4;
        we = 1'($urandom_range(0, 1));
        be = 4'($urandom_range(0, 15));
        wd = $urandom;
        model(i, ad, we, wd, be, erd, eerr, chk);
        txn(i, ad, we, wd, be, $urandom_range(0, 2), rd, err, lat);
        total++;
        if (lat != ((i == 1) ? 1 : 3) || err !== eerr || (chk && rd !== erd)) begin
          bad++;
          $display("FAIL rand inst=%0d addr=%h we=%b be=%b got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                   i, ad, we, be, lat, err, rd, (i == 1) ? 1 : 3, eerr, erd);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 0; req_we[i] = 0; rsp_ready[i] = 0;
      req_addr[i] = '0; req_wdata[i] = '0; req_be[i] = '0;
    end
    test_reset;
    test_basic;
    test_merge;
    test_errors;
    test_backpressure;
    test_reset_mid;
    test_ws0;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete within 500000 time units");
    $fatal(1);
  end
endmodule
